// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient-pair payload and the ByteEncode_12 byte selector.
package kyber_pkg;

    localparam int unsigned KYBER_Q        = 3329;
    localparam int unsigned COEF_W         = 12;
    localparam int unsigned BYTES_PER_PAIR = 3;
    localparam int unsigned IDX_W          = 16;
    localparam int unsigned DIN_W          = 16;
    localparam int unsigned BYTE_W         = 8;

    localparam int unsigned TOTAL_PAIRS_K2 = 256;
    localparam int unsigned TOTAL_PAIRS_K3 = 384;
    localparam int unsigned TOTAL_PAIRS_K4 = 512;

    typedef struct packed {
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        logic [IDX_W-1:0]  idx;
    } pair_t;

    // Little-endian 3-byte packing of two 12-bit coefficients.
    function automatic logic [BYTE_W-1:0] pair_byte(input pair_t p, input logic [1:0] phase);
        logic [BYTE_W-1:0] r;
        case (phase)
            2'd0:    r = p.a[7:0];
            2'd1:    r = {p.b[3:0], p.a[11:8]};
            default: r = p.b[11:4];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/encode12_if.sv
// Pair-in / byte-out bus of the ByteEncode_12 serializer.
interface encode12_if;
    import kyber_pkg::*;

    logic              set;
    logic              readin;
    logic              ready;
    logic [DIN_W-1:0]  din_1;
    logic [DIN_W-1:0]  din_2;
    logic [IDX_W-1:0]  in_index;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic [IDX_W-1:0]  out_index;
    logic              done;

    modport master (
        output set, readin, din_1, din_2, in_index,
        input  ready, dout, dout_valid, out_index, done
    );

    modport slave (
        input  set, readin, din_1, din_2, in_index,
        output ready, dout, dout_valid, out_index, done
    );

endinterface

// File: rtl/cond_sub_q.sv
// Single conditional subtraction of Q from a 12-bit value (x >= Q ? x - Q : x).
module cond_sub_q
    import kyber_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [COEF_W-1:0] x,
    output logic [COEF_W-1:0] y_c
);

    localparam logic [COEF_W-1:0] QV = COEF_W'(Q);

    assign y_c = (x >= QV) ? (x - QV) : x;

endmodule

// File: rtl/encode12.sv
// Kyber ByteEncode_12 serializer: one coefficient pair in, three packed bytes out, one per clock.
module encode12
    import kyber_pkg::*;
#(
    parameter int unsigned TOTAL_PAIRS = TOTAL_PAIRS_K3,
    parameter int unsigned Q           = KYBER_Q
) (
    input  logic       clk,
    input  logic       reset,
    encode12_if.slave  bus
);

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_2 = 2'(BYTES_PER_PAIR - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_PAIRS - 1);

    logic [COEF_W-1:0] a_red_c, b_red_c;
    pair_t             in_pair;
    logic              accept;
    logic              unused_din;

    pair_t             s_pair, s_pair_n;
    logic [1:0]        s_phase, s_phase_n;
    logic              s_busy, s_busy_n;
    pair_t             h_pair, h_pair_n;
    logic              h_valid, h_valid_n;

    logic [BYTE_W-1:0] dout_q, dout_n;
    logic              dout_valid_q, dout_valid_n;
    logic [IDX_W-1:0]  out_index_q, out_index_n;
    logic              done_q, done_n;

    cond_sub_q #(.Q(Q)) u_sub_a (.x(bus.din_1[COEF_W-1:0]), .y_c(a_red_c));
    cond_sub_q #(.Q(Q)) u_sub_b (.x(bus.din_2[COEF_W-1:0]), .y_c(b_red_c));

    assign unused_din = ^{bus.din_1[DIN_W-1:COEF_W], bus.din_2[DIN_W-1:COEF_W]};

    assign in_pair   = '{a: a_red_c, b: b_red_c, idx: bus.in_index};
    assign bus.ready = reset & bus.set & ~h_valid;
    assign accept    = bus.set & bus.readin & bus.ready;

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.out_index  = out_index_q;
    assign bus.done       = done_q;

    // Next-state: emit current byte, advance phase, refill S from input or holding register.
    always_comb begin
        s_pair_n     = s_pair;
        s_phase_n    = s_phase;
        s_busy_n     = s_busy;
        h_pair_n     = h_pair;
        h_valid_n    = h_valid;
        dout_n       = dout_q;
        out_index_n  = out_index_q;
        dout_valid_n = 1'b0;
        done_n       = 1'b0;

        if (bus.set) begin
            if (s_busy) begin
                dout_n       = pair_byte(s_pair, s_phase);
                out_index_n  = (s_pair.idx << 1) + s_pair.idx + {{(IDX_W-2){1'b0}}, s_phase};
                dout_valid_n = 1'b1;
                done_n       = (s_phase == PH_2) && (s_pair.idx == LAST_IDX);
            end

            if (s_busy && (s_phase != PH_2)) begin
                s_phase_n = s_phase + 2'd1;
                if (accept) begin
                    h_pair_n  = in_pair;
                    h_valid_n = 1'b1;
                end
            end else if (accept) begin
                s_pair_n  = in_pair;
                s_phase_n = PH_0;
                s_busy_n  = 1'b1;
            end else if (s_busy && h_valid) begin
                s_pair_n  = h_pair;
                s_phase_n = PH_0;
                h_valid_n = 1'b0;
            end else begin
                s_busy_n  = 1'b0;
                s_phase_n = PH_0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_pair       <= '0;
            s_phase      <= PH_0;
            s_busy       <= 1'b0;
            h_pair       <= '0;
            h_valid      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            out_index_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            s_pair       <= s_pair_n;
            s_phase      <= s_phase_n;
            s_busy       <= s_busy_n;
            h_pair       <= h_pair_n;
            h_valid      <= h_valid_n;
            dout_q       <= dout_n;
            dout_valid_q <= dout_valid_n;
            out_index_q  <= out_index_n;
            done_q       <= done_n;
        end
    end

endmodule

// File: tb/tb_encode12.sv
// Directed self-checking bench for the encode12 ByteEncode_12 serializer.
module tb_encode12;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] mon_q[$];
    int          stamp_q[$];
    logic [31:0] exp_q[$];

    logic [11:0] ra[384];
    logic [11:0] rb[384];

    always #5 clk = ~clk;

    encode12_if bus();

    encode12 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: log every valid byte as {done, out_index, dout}.
    always @(posedge clk) begin
        #1;
        if (bus.dout_valid === 1'b1) begin
            mon_q.push_back({7'd0, bus.done, bus.out_index, bus.dout});
            stamp_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        mon_q.delete();
        stamp_q.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [7:0] b, input logic [15:0] idx, input logic d);
        exp_q.push_back({7'd0, d, idx, b});
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] idx, output int waits);
        bus.din_1    = a;
        bus.din_2    = b;
        bus.in_index = idx;
        bus.readin   = 1'b1;
        waits = 0;
        while (bus.ready !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        if (waits >= 50) chk("ready_timeout", 32'(bus.ready), 32'd1);
        tick();
    endtask

    task automatic wait_q(input string tag, input int n);
        int g;
        g = 0;
        while (mon_q.size() < n && g < 5000) begin
            tick();
            g++;
        end
        repeat (4) tick();
        chk({tag, "_len"}, 32'(mon_q.size()), 32'(n));
    endtask

    task automatic compare_q(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mon_q.size())
                chk($sformatf("%s[%0d]", tag, i), mon_q[i], exp_q[i]);
            else
                chk($sformatf("%s[%0d]_missing", tag, i), 32'hFFFF_FFFF, exp_q[i]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.readin = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int w;
        int waits_total;
        int done_cnt;
        int done_at;
        int idx_err;
        logic [31:0] e0, e1, e2;
        logic [11:0] da, db;

        reset        = 1'b0;
        bus.set      = 1'b1;
        bus.readin   = 1'b0;
        bus.din_1    = '0;
        bus.din_2    = '0;
        bus.in_index = '0;

        // Reset state, with set high so ready must still be forced low.
        repeat (2) tick();
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_index", 32'(bus.out_index), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_ready", 32'(bus.ready), 32'd1);

        // Basic packing with exact latency.
        bus.din_1 = 16'h0123; bus.din_2 = 16'h0ABC; bus.in_index = 16'd0; bus.readin = 1'b1;
        tick();
        bus.readin = 1'b0;
        chk("lat_t0_valid", 32'(bus.dout_valid), 32'd0);
        tick();
        chk("lat_t1", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd0, 8'h23});
        tick();
        chk("lat_t2", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd1, 8'hC1});
        tick();
        chk("lat_t3", {bus.done, bus.dout_valid, bus.out_index, bus.dout}, {1'b0, 1'b1, 16'd2, 8'hAB});
        tick();
        chk("lat_t4_valid", 32'(bus.dout_valid), 32'd0);

        // Reduction and ignored upper bits.
        clear_q();
        send_pair(16'hFD01, 16'hFFFF, 16'd7, w);
        send_pair(16'hF123, 16'h0456, 16'd1, w);
        bus.readin = 1'b0;
        push_exp(8'h00, 16'd21, 1'b0); push_exp(8'hE0, 16'd22, 1'b0); push_exp(8'h2F, 16'd23, 1'b0);
        push_exp(8'h23, 16'd3, 1'b0);  push_exp(8'h61, 16'd4, 1'b0);  push_exp(8'h45, 16'd5, 1'b0);
        wait_q("red", 6);
        compare_q("red");

        // Back-to-back stream with readin held high.
        clear_q();
        waits_total = 0;
        send_pair(16'h0123, 16'h0456, 16'd0, w); waits_total += w;
        send_pair(16'h0789, 16'h0ABC, 16'd1, w); waits_total += w;
        send_pair(16'h00FF, 16'h0100, 16'd2, w); waits_total += w;
        send_pair(16'h0CFF, 16'h0000, 16'd3, w); waits_total += w;
        bus.readin = 1'b0;
        push_exp(8'h23, 16'd0, 1'b0); push_exp(8'h61, 16'd1, 1'b0);  push_exp(8'h45, 16'd2, 1'b0);
        push_exp(8'h89, 16'd3, 1'b0); push_exp(8'hC7, 16'd4, 1'b0);  push_exp(8'hAB, 16'd5, 1'b0);
        push_exp(8'hFF, 16'd6, 1'b0); push_exp(8'h00, 16'd7, 1'b0);  push_exp(8'h10, 16'd8, 1'b0);
        push_exp(8'hFF, 16'd9, 1'b0); push_exp(8'h0C, 16'd10, 1'b0); push_exp(8'h00, 16'd11, 1'b0);
        wait_q("b2b", 12);
        compare_q("b2b");
        chk("b2b_ready_low", 32'(waits_total), 32'd4);
        if (stamp_q.size() == 12) chk("b2b_gap", 32'(stamp_q[11] - stamp_q[0]), 32'd11);
        else chk("b2b_gap_size", 32'(stamp_q.size()), 32'd12);

        // Out-of-range and wrapping indices; last legal index raises done.
        clear_q();
        send_pair(16'h0001, 16'h0002, 16'd384, w);
        send_pair(16'h0001, 16'h0002, 16'd383, w);
        send_pair(16'h0001, 16'h0002, 16'hFFFF, w);
        bus.readin = 1'b0;
        push_exp(8'h01, 16'd1152, 1'b0);  push_exp(8'h20, 16'd1153, 1'b0);  push_exp(8'h00, 16'd1154, 1'b0);
        push_exp(8'h01, 16'd1149, 1'b0);  push_exp(8'h20, 16'd1150, 1'b0);  push_exp(8'h00, 16'd1151, 1'b1);
        push_exp(8'h01, 16'hFFFD, 1'b0);  push_exp(8'h20, 16'hFFFE, 1'b0);  push_exp(8'h00, 16'hFFFF, 1'b0);
        wait_q("ovf", 9);
        compare_q("ovf");

        // Freeze after byte1: outputs hold, valid drops, byte2 resumes one cycle after set returns.
        bus.din_1 = 16'h0123; bus.din_2 = 16'h0ABC; bus.in_index = 16'd2; bus.readin = 1'b1;
        tick();
        bus.readin = 1'b0;
        tick();
        chk("frz_b0", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd6, 8'h23});
        tick();
        chk("frz_b1", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd7, 8'hC1});
        bus.set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("frz_hold%0d", i), {bus.dout_valid, bus.out_index, bus.dout},
                {1'b0, 16'd7, 8'hC1});
        end
        bus.set = 1'b1;
        tick();
        chk("frz_b2", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd8, 8'hAB});
        tick();
        chk("frz_idle", 32'(bus.dout_valid), 32'd0);

        // Reset mid-stream with a pair also parked in the holding register.
        send_pair(16'h0321, 16'h0654, 16'd5, w);
        send_pair(16'h0111, 16'h0222, 16'd6, w);
        bus.readin = 1'b0;
        chk("mid_b0", {bus.dout_valid, bus.out_index, bus.dout}, {1'b1, 16'd15, 8'h21});
        reset = 1'b0;
        #1;
        chk("mid_rst_out", {bus.done, bus.dout_valid, bus.out_index, bus.dout}, 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        clear_q();
        send_pair(16'h0456, 16'h0789, 16'd0, w);
        bus.readin = 1'b0;
        push_exp(8'h56, 16'd0, 1'b0); push_exp(8'h94, 16'd1, 1'b0); push_exp(8'h78, 16'd2, 1'b0);
        wait_q("post_rst", 3);
        compare_q("post_rst");

        // Full k=3 vector round trip.
        do_reset();
        clear_q();
        for (int p = 0; p < 384; p++) begin
            ra[p] = 12'($urandom_range(0, 3328));
            rb[p] = 12'($urandom_range(0, 3328));
        end
        for (int p = 0; p < 384; p++) send_pair({4'd0, ra[p]}, {4'd0, rb[p]}, 16'(p), w);
        bus.readin = 1'b0;
        wait_q("rt", 1152);
        done_cnt = 0;
        done_at  = -1;
        idx_err  = 0;
        for (int k = 0; k < mon_q.size(); k++) begin
            e0 = mon_q[k];
            if (e0[24]) begin
                done_cnt++;
                done_at = int'(e0[23:8]);
            end
            if (int'(e0[23:8]) != k) idx_err++;
        end
        chk("rt_done_cnt", 32'(done_cnt), 32'd1);
        chk("rt_done_at", 32'(done_at), 32'd1151);
        chk("rt_index_seq", 32'(idx_err), 32'd0);
        if (mon_q.size() >= 1152) begin
            for (int p = 0; p < 384; p++) begin
                e0 = mon_q[3*p];
                e1 = mon_q[3*p+1];
                e2 = mon_q[3*p+2];
                da = {e1[3:0], e0[7:0]};
                db = {e2[7:0], e1[7:4]};
                chk($sformatf("rt_a[%0d]", p), 32'(da), 32'(ra[p]));
                chk($sformatf("rt_b[%0d]", p), 32'(db), 32'(rb[p]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
